// File: rtl/divider_result_checker.sv
// Pass/fail monitor for the signed divider: rebuilds quotient*denom +/- remainder
// with a bit-serial shift-add multiplier and compares it with the original dividend.
module divider_result_checker #(
    parameter int WIDTHN = 32,
    parameter int WIDTHD = 16,
    parameter int SIGNED = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTHN-1:0] numer,
    input  logic [WIDTHD-1:0] denom,
    input  logic [WIDTHN-1:0] quotient,
    input  logic [WIDTHD-1:0] remain,
    output logic              out_valid,
    output logic              match,
    output logic              rem_ok,
    output logic              div_zero,
    output logic [15:0]       pass_cnt,
    output logic [15:0]       fail_cnt
);

    localparam int AW = WIDTHN + WIDTHD;
    localparam int CW = $clog2(WIDTHN);

    typedef enum logic [1:0] {IDLE, MUL, CHECK} state_t;

    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic accept;

    logic [WIDTHN-1:0] numer_p0;
    logic [WIDTHN-1:0] q_sh_p0;
    logic [WIDTHD-1:0] d_mag_p0;
    logic [WIDTHD-1:0] remain_p0;
    logic psign_p0, rsign_p0, dzero_p0;

    logic [AW-1:0] d_sh_p1;
    logic [AW-1:0] acc_p1;

    logic signed [AW-1:0] prod_s, rem_s, recon_s, numer_s;
    logic match_nxt, rem_ok_nxt;

    function automatic logic [WIDTHN-1:0] mag_n(input logic [WIDTHN-1:0] v);
        return (SIGNED != 0 && v[WIDTHN-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [WIDTHD-1:0] mag_d(input logic [WIDTHD-1:0] v);
        return (SIGNED != 0 && v[WIDTHD-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = MUL;
            end
            MUL:     if (cnt == CW'(WIDTHN - 1)) state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)           cnt <= '0;
        else if (accept)        cnt <= '0;
        else if (state == MUL)  cnt <= cnt + 1'b1;
    end

    // p0: capture operands as magnitudes plus signs
    // p1: one multiplier bit per cycle, quotient shifted right, denominator left
    always_ff @(posedge clk) begin
        if (accept) begin
            numer_p0  <= numer;
            remain_p0 <= remain;
            q_sh_p0   <= mag_n(quotient);
            d_mag_p0  <= mag_d(denom);
            d_sh_p1   <= {{WIDTHN{1'b0}}, mag_d(denom)};
            psign_p0  <= (SIGNED != 0) && (quotient[WIDTHN-1] ^ denom[WIDTHD-1]);
            rsign_p0  <= (SIGNED != 0) && numer[WIDTHN-1];
            dzero_p0  <= (denom == '0);
            acc_p1    <= '0;
        end else if (state == MUL) begin
            if (q_sh_p0[0]) acc_p1 <= acc_p1 + d_sh_p1;
            q_sh_p0 <= q_sh_p0 >> 1;
            d_sh_p1 <= d_sh_p1 << 1;
        end
    end

    // p2: apply signs and compare at full width so a wrapped quotient cannot alias
    always_comb begin
        prod_s  = psign_p0 ? -$signed(acc_p1) : $signed(acc_p1);
        rem_s   = $signed({{WIDTHN{1'b0}}, remain_p0});
        if (rsign_p0) rem_s = -rem_s;
        recon_s = prod_s + rem_s;
        numer_s = (SIGNED != 0) ? {{WIDTHD{numer_p0[WIDTHN-1]}}, numer_p0}
                                : {{WIDTHD{1'b0}}, numer_p0};
        match_nxt  = !dzero_p0 && (recon_s == numer_s);
        rem_ok_nxt = !dzero_p0 && (remain_p0 < d_mag_p0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            match     <= 1'b0;
            rem_ok    <= 1'b0;
            div_zero  <= 1'b0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
        end else begin
            out_valid <= (state == CHECK);
            if (state == CHECK) begin
                match    <= match_nxt;
                rem_ok   <= rem_ok_nxt;
                div_zero <= dzero_p0;
                if (!dzero_p0) begin
                    if (match_nxt && rem_ok_nxt) pass_cnt <= sat_inc(pass_cnt);
                    else                         fail_cnt <= sat_inc(fail_cnt);
                end
            end
        end
    end

endmodule

// File: tb/tb_divider_result_checker.sv
// Bench for divider_result_checker: signed and unsigned instances share one stimulus
// stream and are compared every cycle against an arithmetic reference model.
module tb_divider_result_checker;

    localparam int WN = 32;
    localparam int WD = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [WN-1:0] numer = '0;
    logic [WD-1:0] denom = '0;
    logic [WN-1:0] quotient = '0;
    logic [WD-1:0] remain = '0;

    logic rdy_s, ov_s, m_s, ro_s, dz_s;
    logic rdy_u, ov_u, m_u, ro_u, dz_u;
    logic [15:0] pc_s, fc_s, pc_u, fc_u;

    int checks = 0;
    int errors = 0;
    int ov_cnt = 0;

    always #5 clk = ~clk;

    divider_result_checker #(.WIDTHN(WN), .WIDTHD(WD), .SIGNED(1)) u_s (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_s),
        .numer(numer), .denom(denom), .quotient(quotient), .remain(remain),
        .out_valid(ov_s), .match(m_s), .rem_ok(ro_s), .div_zero(dz_s),
        .pass_cnt(pc_s), .fail_cnt(fc_s));

    divider_result_checker #(.WIDTHN(WN), .WIDTHD(WD), .SIGNED(0)) u_u (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_u),
        .numer(numer), .denom(denom), .quotient(quotient), .remain(remain),
        .out_valid(ov_u), .match(m_u), .rem_ok(ro_u), .div_zero(dz_u),
        .pass_cnt(pc_u), .fail_cnt(fc_u));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: returns {div_zero, rem_ok, match} from exact integer arithmetic
    function automatic logic [2:0] model(input bit sgn, input logic [31:0] n, input logic [15:0] d,
                                         input logic [31:0] q, input logic [15:0] r);
        longint nn, dd, qq, rr, rec;
        bit dz, m, ro;
        if (sgn) begin
            nn = longint'($signed(n));
            dd = longint'($signed(d));
            qq = longint'($signed(q));
        end else begin
            nn = longint'(n);
            dd = longint'(d);
            qq = longint'(q);
        end
        rr  = longint'(r);
        dz  = (d == 16'd0);
        rec = qq * dd + ((sgn && nn < 0) ? -rr : rr);
        m   = !dz && (rec == nn);
        ro  = !dz && (rr < ((dd < 0) ? -dd : dd));
        return {dz, ro, m};
    endfunction

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // Model state, index 0 = signed instance, 1 = unsigned instance
    int         busy = 0;
    bit         e_ov = 1'b0;
    logic [2:0] p_res [2];
    logic [2:0] e_res [2];
    int         e_pc [2];
    int         e_fc [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            p_res[i] = '0; e_res[i] = '0; e_pc[i] = 0; e_fc[i] = 0;
        end
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                busy = 0;
                e_ov = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    e_res[i] = '0; e_pc[i] = 0; e_fc[i] = 0;
                end
            end else begin
                e_ov = 1'b0;
                if (busy > 0) begin
                    busy--;
                    if (busy == 0) begin
                        e_ov = 1'b1;
                        for (int i = 0; i < 2; i++) begin
                            e_res[i] = p_res[i];
                            if (!p_res[i][2]) begin
                                if (p_res[i][0] && p_res[i][1]) e_pc[i] = sat16(e_pc[i] + 1);
                                else                            e_fc[i] = sat16(e_fc[i] + 1);
                            end
                        end
                    end
                end else if (in_valid) begin
                    busy = WN + 1;
                    p_res[0] = model(1'b1, numer, denom, quotient, remain);
                    p_res[1] = model(1'b0, numer, denom, quotient, remain);
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (ov_s) ov_cnt++;
    end

    // Per-cycle comparison of both instances against the model
    initial forever begin
        @(negedge clk);
        chk("s.in_ready",  64'(rdy_s), 64'(busy == 0));
        chk("s.out_valid", 64'(ov_s),  64'(e_ov));
        chk("s.match",     64'(m_s),   64'(e_res[0][0]));
        chk("s.rem_ok",    64'(ro_s),  64'(e_res[0][1]));
        chk("s.div_zero",  64'(dz_s),  64'(e_res[0][2]));
        chk("s.pass_cnt",  64'(pc_s),  64'(e_pc[0]));
        chk("s.fail_cnt",  64'(fc_s),  64'(e_fc[0]));
        chk("u.in_ready",  64'(rdy_u), 64'(busy == 0));
        chk("u.out_valid", 64'(ov_u),  64'(e_ov));
        chk("u.match",     64'(m_u),   64'(e_res[1][0]));
        chk("u.rem_ok",    64'(ro_u),  64'(e_res[1][1]));
        chk("u.div_zero",  64'(dz_u),  64'(e_res[1][2]));
        chk("u.pass_cnt",  64'(pc_u),  64'(e_pc[1]));
        chk("u.fail_cnt",  64'(fc_u),  64'(e_fc[1]));
    end

    // One tuple, then wait to the cycle after edge WN+1 where out_valid must be high
    task automatic send(input logic [31:0] n, input logic [15:0] d,
                        input logic [31:0] q, input logic [15:0] r);
        @(negedge clk);
        numer = n; denom = d; quotient = q; remain = r; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("pin.busy_after_accept", 64'(rdy_s), 64'(0));
        in_valid = 1'b0;
        numer = $urandom; quotient = $urandom;
        repeat (WN + 1) @(posedge clk);
        @(negedge clk);
        chk("pin.out_valid_edge33", 64'(ov_s), 64'(1));
        chk("pin.in_ready_edge33",  64'(rdy_s), 64'(1));
    endtask

    task automatic pin_s(input string name, input bit m, input bit ro, input bit dz,
                         input int pc, input int fc);
        chk({name, ".match"},    64'(m_s),  64'(m));
        chk({name, ".rem_ok"},   64'(ro_s), 64'(ro));
        chk({name, ".div_zero"}, 64'(dz_s), 64'(dz));
        chk({name, ".pass_cnt"}, 64'(pc_s), 64'(pc));
        chk({name, ".fail_cnt"}, 64'(fc_s), 64'(fc));
    endtask

    task automatic rand_tuple();
        logic [31:0] n, q;
        logic [15:0] d, r;
        longint nn, dd, qq, rr;
        int kind;
        kind = $urandom_range(0, 9);
        n = $urandom;
        d = 16'($urandom);
        if ($urandom_range(0, 3) == 0) n = 32'($signed(16'($urandom)));
        if (d == 16'd0) d = 16'd1;
        nn = longint'($signed(n));
        dd = longint'($signed(d));
        qq = nn / dd;
        rr = nn - qq * dd;
        if (rr < 0) rr = -rr;
        q = 32'(qq);
        r = 16'(rr);
        if (kind == 5 || kind == 6) begin
            nn = longint'(n);
            dd = longint'(d);
            q  = 32'(nn / dd);
            r  = 16'(nn % dd);
        end else if (kind == 7) begin
            if ($urandom_range(0, 1) == 1) q = q ^ (32'd1 << $urandom_range(0, 31));
            else                           r = r ^ (16'd1 << $urandom_range(0, 15));
        end else if (kind == 8) begin
            d = 16'd0;
        end else if (kind == 9) begin
            n = 32'h8000_0000; d = 16'hFFFF; q = 32'h8000_0000; r = 16'd0;
        end
        numer = n; denom = d; quotient = q; remain = r;
    endtask

    initial begin
        int ov_base;
        repeat (3) @(negedge clk);
        chk("rst.in_ready",  64'(rdy_s), 64'(1));
        chk("rst.out_valid", 64'(ov_s),  64'(0));
        reset_n = 1'b1;
        @(negedge clk);
        pin_s("rst", 1'b0, 1'b0, 1'b0, 0, 0);

        send(32'd8, -16'sd3, -32'sd2, 16'd2);
        pin_s("pos_neg", 1'b1, 1'b1, 1'b0, 1, 0);
        send(-32'sd16, -16'sd3, 32'd5, 16'd1);
        pin_s("neg_neg", 1'b1, 1'b1, 1'b0, 2, 0);
        send(-32'sd13, 16'd3, -32'sd4, 16'd1);
        pin_s("neg_pos", 1'b1, 1'b1, 1'b0, 3, 0);
        send(32'd15, 16'd4, 32'd3, 16'd2);
        pin_s("bad_q", 1'b0, 1'b1, 1'b0, 3, 1);
        send(32'd15, 16'd4, 32'd3, 16'd4);
        pin_s("bad_r", 1'b0, 1'b0, 1'b0, 3, 2);
        send(32'd5, 16'd0, 32'd7, 16'd3);
        pin_s("dzero", 1'b0, 1'b0, 1'b1, 3, 2);
        send(32'h8000_0000, 16'hFFFF, 32'h8000_0000, 16'd0);
        pin_s("ovf", 1'b0, 1'b1, 1'b0, 3, 3);
        chk("model.fail_s", 64'(e_fc[0]), 64'(3));

        // Back-to-back with in_valid held high
        @(negedge clk);
        numer = 32'd100; denom = 16'd7; quotient = 32'd14; remain = 16'd2; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        numer = -32'sd100; denom = 16'd7; quotient = -32'sd14; remain = 16'd2;
        repeat (WN + 1) @(posedge clk);
        @(negedge clk);
        chk("b2b.ov1", 64'(ov_s), 64'(1));
        @(posedge clk);
        @(negedge clk);
        chk("b2b.busy2", 64'(rdy_s), 64'(0));
        numer = 32'd9; denom = 16'd3; quotient = 32'd3; remain = 16'd0;
        repeat (WN + 1) @(posedge clk);
        @(negedge clk);
        chk("b2b.ov2", 64'(ov_s), 64'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (WN + 1) @(posedge clk);
        @(negedge clk);
        chk("b2b.ov3", 64'(ov_s), 64'(1));
        pin_s("b2b", 1'b1, 1'b1, 1'b0, 6, 3);
        @(negedge clk);
        chk("b2b.ov_end", 64'(ov_s), 64'(0));

        // Reset mid-transaction
        @(negedge clk);
        numer = 32'd8; denom = -16'sd3; quotient = -32'sd2; remain = 16'd2; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset_n = 1'b0;
        @(negedge clk);
        pin_s("midrst", 1'b0, 1'b0, 1'b0, 0, 0);
        reset_n = 1'b1;
        ov_base = ov_cnt;
        repeat (40) @(negedge clk);
        chk("midrst.no_pulse", 64'(ov_cnt - ov_base), 64'(0));
        chk("midrst.in_ready", 64'(rdy_s), 64'(1));

        send(32'hFFFF_FFFF, 16'h00FF, 32'h0101_0101, 16'd0);
        chk("uns.match",    64'(m_u),  64'(1));
        chk("uns.rem_ok",   64'(ro_u), 64'(1));
        chk("uns.pass_cnt", 64'(pc_u), 64'(1));
        chk("uns.signed_fail", 64'(fc_s), 64'(1));

        // Randomised stream with idle gaps and inputs changing every cycle
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            rand_tuple();
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (WN + 4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
